// File: rtl/comparator_2bit.sv
// -----------------------------------------------------------------------------
// comparator_2bit
//
// Unsigned magnitude comparator for two WIDTH-bit operands (fixed at 2 bits).
// The greater/equal/less flags are purely combinational and stay valid while
// reset is asserted. A registered copy of the flags, a one-cycle "changed"
// status pulse and three saturating outcome counters are kept for status and
// debug use.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous reset, active low
//   a        in   WIDTH  operand A, unsigned
//   b        in   WIDTH  operand B, unsigned
//   a_gt_b   out  1      combinational, 1 iff a >  b
//   a_eq_b   out  1      combinational, 1 iff a == b
//   a_lt_b   out  1      combinational, 1 iff a <  b
//   cnt_en   in   1      counters sample the current outcome on each edge
//   cnt_clr  in   1      synchronous clear of all counters (wins over cnt_en)
//   gt_q     out  1      registered a_gt_b
//   eq_q     out  1      registered a_eq_b
//   lt_q     out  1      registered a_lt_b
//   changed  out  1      pulse: registered flags differ from their prior value
//   gt_cnt   out  CNT_W  enabled cycles with a >  b (saturating)
//   eq_cnt   out  CNT_W  enabled cycles with a == b (saturating)
//   lt_cnt   out  CNT_W  enabled cycles with a <  b (saturating)
// -----------------------------------------------------------------------------
module comparator_2bit #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    output logic             gt_q,
    output logic             eq_q,
    output logic             lt_q,
    output logic             changed,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    // Flag vector ordering used throughout: {gt, eq, lt}.
    // Reset value is the one-hot "equal" state, matching a = b = 0.
    localparam logic [2:0] FLAGS_RST = 3'b010;

    // Saturating increment: an all-ones counter holds instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Counter next value: clear has priority, otherwise count when selected.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] v,
        input logic             clr,
        input logic             inc
    );
        logic [CNT_W-1:0] r;
        if (clr) begin
            r = {CNT_W{1'b0}};
        end else if (inc) begin
            r = sat_inc(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [2:0]       cmp_s;
    logic [2:0]       flags_q, flags_d;
    logic [2:0]       prev_q,  prev_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;

    // Combinational unsigned compare; independent of clk and rst_n.
    always_comb begin
        cmp_s = 3'b000;
        if (a > b) begin
            cmp_s = 3'b100;
        end else if (a == b) begin
            cmp_s = 3'b010;
        end else begin
            cmp_s = 3'b001;
        end
    end

    assign a_gt_b = cmp_s[2];
    assign a_eq_b = cmp_s[1];
    assign a_lt_b = cmp_s[0];

    // Next-state logic for flags, change detector and counters.
    always_comb begin
        flags_d   = cmp_s;
        // prev_q trails flags_q by one edge, so "changed" reports a flag
        // transition one cycle after the registered flags take it.
        prev_d    = flags_q;
        changed_d = 1'b0;
        if (flags_q != prev_q) begin
            changed_d = 1'b1;
        end else begin
            changed_d = 1'b0;
        end
        gt_cnt_d  = cnt_next(gt_cnt_q, cnt_clr, cnt_en & cmp_s[2]);
        eq_cnt_d  = cnt_next(eq_cnt_q, cnt_clr, cnt_en & cmp_s[1]);
        lt_cnt_d  = cnt_next(lt_cnt_q, cnt_clr, cnt_en & cmp_s[0]);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= FLAGS_RST;
            prev_q    <= FLAGS_RST;
            changed_q <= 1'b0;
            gt_cnt_q  <= {CNT_W{1'b0}};
            eq_cnt_q  <= {CNT_W{1'b0}};
            lt_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            flags_q   <= flags_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
            gt_cnt_q  <= gt_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
        end
    end

    assign gt_q    = flags_q[2];
    assign eq_q    = flags_q[1];
    assign lt_q    = flags_q[0];
    assign changed = changed_q;
    assign gt_cnt  = gt_cnt_q;
    assign eq_cnt  = eq_cnt_q;
    assign lt_cnt  = lt_cnt_q;

endmodule

// File: tb/tb_comparator_2bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_2bit
//
// Table-driven, self-checking bench for comparator_2bit. A hand-written table
// of all 16 operand pairs supplies the expected combinational flags. A small
// reference model of the registered outputs pushes expected values into a
// scoreboard queue when stimulus is driven; they are popped and compared one
// time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_comparator_2bit;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       a;
    logic [1:0]       b;
    logic             a_gt_b, a_eq_b, a_lt_b;
    logic             cnt_en, cnt_clr;
    logic             gt_q, eq_q, lt_q, changed;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

    comparator_2bit #(.WIDTH(2), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .a_gt_b  (a_gt_b),
        .a_eq_b  (a_eq_b),
        .a_lt_b  (a_lt_b),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .gt_q    (gt_q),
        .eq_q    (eq_q),
        .lt_q    (lt_q),
        .changed (changed),
        .gt_cnt  (gt_cnt),
        .eq_cnt  (eq_cnt),
        .lt_cnt  (lt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       gt;
        logic       eq;
        logic       lt;
    } vec_t;

    typedef struct {
        logic [2:0]       flags;
        logic             chg;
        logic [CNT_W-1:0] gc;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] lc;
    } exp_t;

    vec_t vecs [16];
    exp_t sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the registered outputs.
    logic [2:0]       m_flags;
    logic [2:0]       m_prev;
    logic [CNT_W-1:0] m_gc, m_ec, m_lc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = 3'b010;
        m_prev  = 3'b010;
        m_gc    = '0;
        m_ec    = '0;
        m_lc    = '0;
    endtask

    function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check_regs(input exp_t e);
        chk("gt_q",    32'(gt_q),    32'(e.flags[2]));
        chk("eq_q",    32'(eq_q),    32'(e.flags[1]));
        chk("lt_q",    32'(lt_q),    32'(e.flags[0]));
        chk("changed", 32'(changed), 32'(e.chg));
        chk("gt_cnt",  32'(gt_cnt),  32'(e.gc));
        chk("eq_cnt",  32'(eq_cnt),  32'(e.ec));
        chk("lt_cnt",  32'(lt_cnt),  32'(e.lc));
    endtask

    // Drive one cycle: entered one time unit after a rising edge, checks the
    // combinational flags 5 units after the change, then the registered
    // outputs one unit after the next edge.
    task automatic step(input logic [1:0] sa, input logic [1:0] sb,
                        input logic en, input logic clr);
        vec_t v;
        exp_t e;
        a = sa; b = sb; cnt_en = en; cnt_clr = clr;
        v = vecs[{sa, sb}];
        #5;
        chk("a_gt_b", 32'(a_gt_b), 32'(v.gt));
        chk("a_eq_b", 32'(a_eq_b), 32'(v.eq));
        chk("a_lt_b", 32'(a_lt_b), 32'(v.lt));
        e.chg   = (m_flags != m_prev);
        m_prev  = m_flags;
        m_flags = {v.gt, v.eq, v.lt};
        if (clr) begin
            m_gc = '0; m_ec = '0; m_lc = '0;
        end else if (en) begin
            if (v.gt) m_gc = m_inc(m_gc);
            if (v.eq) m_ec = m_inc(m_ec);
            if (v.lt) m_lc = m_inc(m_lc);
        end
        e.flags = m_flags;
        e.gc = m_gc; e.ec = m_ec; e.lc = m_lc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check_regs(sb_q.pop_front());
        end
    endtask

    initial begin
        // a, b, gt, eq, lt
        vecs[ 0] = '{2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[ 1] = '{2'd0, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[ 2] = '{2'd0, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[ 3] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[ 4] = '{2'd1, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[ 5] = '{2'd1, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[ 6] = '{2'd1, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[ 7] = '{2'd1, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[ 8] = '{2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[ 9] = '{2'd2, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'd2, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'd2, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{2'd3, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2'd3, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{2'd3, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{2'd3, 2'd3, 1'b0, 1'b1, 1'b0};

        // Reset held with a=3, b=1: flags live, registers in reset state.
        rst_n = 1'b0; a = 2'd3; b = 2'd1; cnt_en = 1'b1; cnt_clr = 1'b0;
        model_reset();
        #2;
        chk("rst_a_gt_b", 32'(a_gt_b), 32'd1);
        chk("rst_a_eq_b", 32'(a_eq_b), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_gt_q", 32'(gt_q), 32'd0);
        chk("rst_eq_q", 32'(eq_q), 32'd1);
        chk("rst_lt_q", 32'(lt_q), 32'd0);
        chk("rst_changed", 32'(changed), 32'd0);
        chk("rst_gt_cnt", 32'(gt_cnt), 32'd0);
        chk("rst_eq_cnt", 32'(eq_cnt), 32'd0);
        chk("rst_lt_cnt", 32'(lt_cnt), 32'd0);
        rst_n = 1'b1;

        // Latency: a=1, b=2 held after release.
        step(2'd1, 2'd2, 1'b0, 1'b0);
        chk("lat_lt_q_edge1", 32'(lt_q), 32'd1);
        chk("lat_changed_edge1", 32'(changed), 32'd0);
        step(2'd1, 2'd2, 1'b0, 1'b0);
        chk("lat_changed_edge2", 32'(changed), 32'd1);
        step(2'd1, 2'd2, 1'b0, 1'b0);
        chk("lat_changed_edge3", 32'(changed), 32'd0);

        // Counting: four enabled edges after a clear.
        step(2'd0, 2'd0, 1'b0, 1'b1);
        step(2'd0, 2'd0, 1'b1, 1'b0);
        step(2'd3, 2'd0, 1'b1, 1'b0);
        step(2'd1, 2'd2, 1'b1, 1'b0);
        step(2'd2, 2'd2, 1'b1, 1'b0);
        chk("cnt_gt", 32'(gt_cnt), 32'd1);
        chk("cnt_eq", 32'(eq_cnt), 32'd2);
        chk("cnt_lt", 32'(lt_cnt), 32'd1);

        // Exhaustive sweep of all operand pairs, counters idle.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].a, vecs[i].b, 1'b0, 1'b0);
        end

        // Saturation: 300 equal, enabled edges; then clear with enable.
        for (int i = 0; i < 300; i++) begin
            step(2'd2, 2'd2, 1'b1, 1'b0);
        end
        chk("sat_eq_cnt", 32'(eq_cnt), 32'd255);
        step(2'd2, 2'd2, 1'b1, 1'b1);
        chk("clr_gt_cnt", 32'(gt_cnt), 32'd0);
        chk("clr_eq_cnt", 32'(eq_cnt), 32'd0);
        chk("clr_lt_cnt", 32'(lt_cnt), 32'd0);

        // Async reset mid-count: drop between edges, no clock needed.
        step(2'd3, 2'd0, 1'b1, 1'b0);
        step(2'd3, 2'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gt_q", 32'(gt_q), 32'd0);
        chk("arst_eq_q", 32'(eq_q), 32'd1);
        chk("arst_changed", 32'(changed), 32'd0);
        chk("arst_gt_cnt", 32'(gt_cnt), 32'd0);
        chk("arst_a_gt_b", 32'(a_gt_b), 32'd1);
        a = 2'd0; b = 2'd3;
        #1;
        chk("arst_a_lt_b", 32'(a_lt_b), 32'd1);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Free-running edge after release counted (a<b, en=1).
        m_prev  = m_flags;
        m_flags = 3'b001;
        m_lc    = 8'd1;
        chk("resume_lt_cnt0", 32'(lt_cnt), 32'd1);
        step(2'd3, 2'd0, 1'b1, 1'b0);
        chk("resume_gt_cnt", 32'(gt_cnt), 32'd1);
        chk("resume_eq_cnt", 32'(eq_cnt), 32'd0);

        if (sb_q.size() != 0) begin
            chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
